// File: rtl/cd_limit_ctrl_if.sv
// Request/response and divider-control signals between configuration sources,
// cd_limit_ctrl and the clock-divider counter.
interface cd_limit_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_a_valid;
    logic [WIDTH-1:0] req_a_limit;
    logic             req_a_ready;
    logic             req_b_valid;
    logic [WIDTH-1:0] req_b_limit;
    logic             req_b_ready;
    logic             div_clkout;
    logic [WIDTH-1:0] div_limit;
    logic             div_rst;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             err;

    // Requesters and divider feedback.
    modport master (
        output req_a_valid, req_a_limit, req_b_valid, req_b_limit, div_clkout,
        input  req_a_ready, req_b_ready, div_limit, div_rst, busy, done, done_id, err
    );

    // Controller.
    modport slave (
        input  req_a_valid, req_a_limit, req_b_valid, req_b_limit, div_clkout,
        output req_a_ready, req_b_ready, div_limit, div_rst, busy, done, done_id, err
    );
endinterface

// File: rtl/cd_limit_ctrl.sv
// Divide-limit reconfiguration controller: round-robin arbitration of two
// requesters, limit update on the divided clock's falling edge, divider reset hold.
module cd_limit_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEFAULT_LIMIT = 2,
    parameter int unsigned HOLD_CYC      = 2
) (
    input  logic           clk,
    input  logic           rst,
    cd_limit_ctrl_if.slave bus
);
    localparam int unsigned CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        S_INIT      = 2'd0,
        S_IDLE      = 2'd1,
        S_WAIT_EDGE = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             clk_q, clk_q_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] div_limit_q, div_limit_d;
    logic             div_rst_q, div_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             err_q, err_d;

    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] grant_limit;
    logic             hold_last;
    logic             fall;

    assign hold_last   = (hold_cnt_q == CW'(HOLD_CYC - 1));
    assign fall        = clk_q & ~bus.div_clkout;
    assign grant_limit = grant_id ? bus.req_b_limit : bus.req_a_limit;

    // Round-robin arbitration; only IDLE ever grants.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.req_a_valid && bus.req_b_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (bus.req_a_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req_b_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // State register together with all datapath/output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            hold_cnt_q   <= '0;
            pend_q       <= '0;
            clk_q        <= 1'b0;
            last_grant_q <= 1'b1;
            div_limit_q  <= WIDTH'(DEFAULT_LIMIT);
            div_rst_q    <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_q       <= pend_d;
            clk_q        <= clk_q_d;
            last_grant_q <= last_grant_d;
            div_limit_q  <= div_limit_d;
            div_rst_q    <= div_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic; rejected and equal-limit grants stay in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
                if (hold_last) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (grant_valid && (grant_limit != '0) && (grant_limit != div_limit_q))
                    state_d = S_WAIT_EDGE;
            end
            S_WAIT_EDGE: begin
                if (fall) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_last) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        hold_cnt_d   = '0;
        pend_d       = pend_q;
        clk_q_d      = 1'b0;
        last_grant_d = last_grant_q;
        div_limit_d  = div_limit_q;
        div_rst_d    = div_rst_q;
        busy_d       = (state_d != S_IDLE);
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        err_d        = 1'b0;
        case (state_q)
            S_INIT: begin
                hold_cnt_d = hold_last ? '0 : hold_cnt_q + CW'(1);
                if (hold_last) div_rst_d = 1'b0;
            end
            S_IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant_id;
                    if (grant_limit == '0) begin
                        err_d     = 1'b1;
                        done_id_d = grant_id;
                    end else if (grant_limit == div_limit_q) begin
                        done_d    = 1'b1;
                        done_id_d = grant_id;
                    end else begin
                        pend_d = grant_limit;
                    end
                end
            end
            S_WAIT_EDGE: begin
                // Edge register only tracks while waiting, so older edges are ignored.
                clk_q_d = bus.div_clkout;
                if (fall) begin
                    div_limit_d = pend_q;
                    div_rst_d   = 1'b1;
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_last ? '0 : hold_cnt_q + CW'(1);
                if (hold_last) begin
                    div_rst_d = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = last_grant_q;
                end
            end
            default: ;
        endcase
    end

    // Ready is an acceptance strobe in the grant cycle itself.
    assign bus.req_a_ready = grant_valid & ~grant_id;
    assign bus.req_b_ready = grant_valid & grant_id;
    assign bus.div_limit   = div_limit_q;
    assign bus.div_rst     = div_rst_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.err         = err_q;

endmodule
